// File: rtl/wb_trace_fifo.sv
// Show-ahead FIFO for retired RF writes; head appears on trace_* one cycle after push.
// Pops are valid/ready; when full without a pop, new entries are dropped and counted.
module wb_trace_fifo #(
   parameter int DEPTH       = 16,
   parameter int AFULL_TH    = DEPTH - 2,
   parameter bit FILTER_ZERO = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       capture_en,
   input  logic [31:0]                debug_wb_pc,
   input  logic [3:0]                 debug_wb_rf_wen,
   input  logic [4:0]                 debug_wb_rf_wnum,
   input  logic [31:0]                debug_wb_rf_wdata,
   output logic                       trace_valid,
   input  logic                       trace_ready,
   output logic [31:0]                trace_pc,
   output logic [3:0]                 trace_wen,
   output logic [4:0]                 trace_wnum,
   output logic [31:0]                trace_wdata,
   output logic                       stallreq_from_trace,
   output logic [$clog2(DEPTH):0]     trace_level,
   output logic [15:0]                trace_ovf_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

   logic [72:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          valid_q, valid_d, stall_q, stall_d;
   logic [72:0]   head_q, head_d;
   logic [15:0]   ovf_q, ovf_d;
   logic [72:0]   wr_entry;
   logic          push_req, push_acc, pop;

   always_comb begin
      wr_entry = {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata};
      push_req = capture_en && (debug_wb_rf_wen != 4'd0) &&
                 !(FILTER_ZERO && (debug_wb_rf_wnum == 5'd0));
      pop      = valid_q && trace_ready;
      // count never exceeds DEPTH, so "not full" is the same as count < DEPTH
      push_acc = push_req && ((count_q != DEPTH_C) || pop);
      wr_ptr_d = push_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push_acc) - CW'(pop);
      ovf_d    = (push_req && !push_acc && (ovf_q != 16'hFFFF)) ? ovf_q + 16'd1 : ovf_q;
      valid_d  = (count_d != '0);
      stall_d  = (count_d >= AFULL_C);
      head_d   = head_q;
      // The next head may be the entry being written this very cycle.
      if (valid_d)
         head_d = (push_acc && (wr_ptr_q == rd_ptr_d)) ? wr_entry : mem[rd_ptr_d];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         stall_q  <= 1'b0;
         head_q   <= '0;
         ovf_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         stall_q  <= stall_d;
         head_q   <= head_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_acc)
         mem[wr_ptr_q] <= wr_entry;
   end

   assign trace_valid         = valid_q;
   assign trace_pc            = head_q[72:41];
   assign trace_wen           = head_q[40:37];
   assign trace_wnum          = head_q[36:32];
   assign trace_wdata         = head_q[31:0];
   assign stallreq_from_trace = stall_q;
   assign trace_level         = count_q;
   assign trace_ovf_cnt       = ovf_q;
endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench for wb_trace_fifo with a reference count model and an entry scoreboard.
module tb_wb_trace_fifo;
   localparam int DEPTH = 16;
   localparam int AFULL = DEPTH - 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        capture_en;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;
   logic        trace_valid;
   logic        trace_ready;
   logic [31:0] trace_pc;
   logic [3:0]  trace_wen;
   logic [4:0]  trace_wnum;
   logic [31:0] trace_wdata;
   logic        stallreq_from_trace;
   logic [4:0]  trace_level;
   logic [15:0] trace_ovf_cnt;

   wb_trace_fifo #(.DEPTH(DEPTH), .AFULL_TH(AFULL), .FILTER_ZERO(1'b1)) dut (
      .clk(clk), .rst(rst), .capture_en(capture_en),
      .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
      .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
      .trace_valid(trace_valid), .trace_ready(trace_ready),
      .trace_pc(trace_pc), .trace_wen(trace_wen), .trace_wnum(trace_wnum),
      .trace_wdata(trace_wdata), .stallreq_from_trace(stallreq_from_trace),
      .trace_level(trace_level), .trace_ovf_cnt(trace_ovf_cnt)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [72:0] sb[$];
   int          m_count = 0;
   int          m_ovf   = 0;

   task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [72:0] head();
      return {trace_pc, trace_wen, trace_wnum, trace_wdata};
   endfunction

   task automatic check_state(input string tag);
      check({tag, ".valid"}, 73'(trace_valid), 73'(m_count != 0));
      check({tag, ".level"}, 73'(trace_level), 73'(m_count));
      check({tag, ".stall"}, 73'(stallreq_from_trace), 73'(m_count >= AFULL));
      check({tag, ".ovf"},   73'(trace_ovf_cnt), 73'(m_ovf));
      if (m_count != 0 && sb.size() != 0)
         check({tag, ".head"}, head(), sb[0]);
   endtask

   // Drive one cycle of inputs, update the model, advance one edge and check.
   task automatic step(input string tag, input logic cap, input logic [3:0] wen,
                       input logic [4:0] wnum, input logic [31:0] pc,
                       input logic [31:0] wdata, input logic rdy);
      logic pop, req;
      capture_en        = cap;
      debug_wb_rf_wen   = wen;
      debug_wb_rf_wnum  = wnum;
      debug_wb_pc       = pc;
      debug_wb_rf_wdata = wdata;
      trace_ready       = rdy;
      pop = rdy && (m_count != 0);
      req = cap && (wen != 4'd0) && (wnum != 5'd0);
      if (pop) begin
         void'(sb.pop_front());
         m_count--;
      end
      if (req) begin
         if (m_count < DEPTH) begin
            sb.push_back({pc, wen, wnum, wdata});
            m_count++;
         end else if (m_ovf != 16'hFFFF) begin
            m_ovf++;
         end
      end
      @(posedge clk);
      #1;
      check_state(tag);
   endtask

   task automatic idle(input string tag, input logic rdy);
      step(tag, 1'b1, 4'd0, 5'd0, 32'd0, 32'd0, rdy);
   endtask

   initial begin
      rst = 1'b0;
      capture_en = 1'b0; trace_ready = 1'b0;
      debug_wb_pc = '0; debug_wb_rf_wen = '0; debug_wb_rf_wnum = '0; debug_wb_rf_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check_state("reset");
      check("reset.head", head(), 73'd0);
      rst = 1'b1;

      // Single write, appears the next cycle, then consumed.
      step("t1.push", 1'b1, 4'hF, 5'd2, 32'hBFC0_0000, 32'h1234, 1'b0);
      check("t1.head", head(), {32'hBFC0_0000, 4'hF, 5'd2, 32'h1234});
      step("t1.pop", 1'b1, 4'd0, 5'd0, 32'd0, 32'd0, 1'b1);
      check("t1.empty", 73'(trace_level), 73'd0);

      // Filtered writes: $0 and no byte enables.
      step("t2.zero", 1'b1, 4'hF, 5'd0, 32'h100, 32'hAAAA, 1'b0);
      step("t2.nowen", 1'b1, 4'h0, 5'd5, 32'h104, 32'hBBBB, 1'b0);
      step("t2.capoff", 1'b0, 4'hF, 5'd5, 32'h108, 32'hCCCC, 1'b1);

      // Fill past full with the consumer stalled.
      for (int i = 1; i <= 18; i++)
         step("t3.fill", 1'b1, 4'h3, 5'(i), 32'h2000 + 32'(i * 4), 32'(i * 32'h11), 1'b0);
      check("t3.level16", 73'(trace_level), 73'd16);
      check("t3.ovf2", 73'(trace_ovf_cnt), 73'd2);

      // Push and pop together while full.
      check("t4.oldest", head(), {32'h2004, 4'h3, 5'd1, 32'h11});
      step("t4.pushpop", 1'b1, 4'hC, 5'd31, 32'h3000, 32'hDEAD_BEEF, 1'b1);
      check("t4.level", 73'(trace_level), 73'd16);
      check("t4.ovf", 73'(trace_ovf_cnt), 73'd2);

      for (int i = 0; i < 17; i++) idle("t3.drain", 1'b1);
      check("t3.drained", 73'(sb.size()), 73'd0);

      // Streaming push and pop every cycle.
      for (int i = 0; i < 100; i++)
         step("t5.stream", 1'b1, 4'(i % 15 + 1), 5'(i % 31 + 1),
              32'h4000 + 32'(i * 4), $urandom, 1'b1);
      idle("t5.tail", 1'b1);

      // Asynchronous reset mid-stream.
      for (int i = 0; i < 7; i++)
         step("t6.fill", 1'b1, 4'hF, 5'd7, 32'h5000 + 32'(i * 4), 32'(i), 1'b0);
      check("t6.level7", 73'(trace_level), 73'd7);
      #2 rst = 1'b0;
      #1;
      sb.delete(); m_count = 0; m_ovf = 0;
      check_state("t6.async");
      check("t6.head0", head(), 73'd0);
      @(negedge clk);
      rst = 1'b1;
      step("t6.push", 1'b1, 4'h1, 5'd9, 32'h6000, 32'h6666, 1'b0);
      check("t6.alone", 73'(trace_level), 73'd1);
      idle("t6.pop", 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
